// File: rtl/interrupt_controller_if.sv
// CPU-side bus for the interrupt controller: request lines, I-flag control,
// acknowledge, and the IN/OUT port-space access signals.
interface interrupt_controller_if #(
    parameter int unsigned NUM_SRC = 8
);
    logic [NUM_SRC-1:0] IRQ;
    logic               I_SET;
    logic               I_CLR;
    logic               INT_ACK;
    logic               IO_STRB;
    logic [7:0]         PORT_ID;
    logic [7:0]         OUT_PORT;
    logic               INTERUPT;
    logic               I_FLAG;
    logic [2:0]         IRQ_ID;
    logic [7:0]         IN_DATA;
    logic               IN_HIT;

    modport slave (
        input  IRQ, I_SET, I_CLR, INT_ACK, IO_STRB, PORT_ID, OUT_PORT,
        output INTERUPT, I_FLAG, IRQ_ID, IN_DATA, IN_HIT
    );

    modport master (
        output IRQ, I_SET, I_CLR, INT_ACK, IO_STRB, PORT_ID, OUT_PORT,
        input  INTERUPT, I_FLAG, IRQ_ID, IN_DATA, IN_HIT
    );
endinterface

// File: rtl/interrupt_controller.sv
// Interrupt controller for the RAT CPU: synchronises and edge-detects up to 8
// request lines, latches them as pending, and raises one masked request.
module interrupt_controller #(
    parameter int unsigned NUM_SRC = 8,
    parameter logic [7:0]  MASK_ID = 8'h20,
    parameter logic [7:0]  PEND_ID = 8'h21,
    parameter logic [7:0]  ID_ID   = 8'h22
) (
    input  logic                   CLK,
    input  logic                   RESET_N,
    interrupt_controller_if.slave  bus
);
    localparam logic [7:0] SRC_MASK = 8'((16'd1 << NUM_SRC) - 16'd1);

    logic [7:0] irq_ext;
    logic [7:0] s1_q, s1_d;
    logic [7:0] s2_q, s2_d;
    logic [7:0] s3_q, s3_d;
    logic [7:0] pend_q, pend_d;
    logic [7:0] mask_q, mask_d;
    logic       iflag_q, iflag_d;
    logic [2:0] irq_id_q, irq_id_d;

    logic [7:0] edge_det;
    logic [7:0] active;
    logic [7:0] ack_onehot;
    logic [2:0] ack_idx;
    logic       ack_fire;
    logic       wr_mask;
    logic       wr_pend;
    logic [7:0] clr;

    always_comb begin
        irq_ext = '0;
        irq_ext[NUM_SRC-1:0] = bus.IRQ;
    end

    assign edge_det = s2_q & ~s3_q;
    assign active   = pend_q & mask_q;
    assign ack_fire = bus.INT_ACK & (|active);
    assign wr_mask  = bus.IO_STRB & (bus.PORT_ID == MASK_ID);
    assign wr_pend  = bus.IO_STRB & (bus.PORT_ID == PEND_ID);

    // Isolate the lowest set bit of active: lowest index has priority.
    assign ack_onehot = active & (~active + 8'd1);

    always_comb begin
        ack_idx = '0;
        for (int unsigned i = 8; i > 0; i--) begin
            if (active[i-1]) ack_idx = 3'(i - 1);
        end
    end

    always_comb begin
        s1_d = irq_ext;
        s2_d = s1_q;
        s3_d = s2_q;

        clr = '0;
        if (ack_fire) clr = clr | ack_onehot;
        if (wr_pend)  clr = clr | bus.OUT_PORT;
        // Set wins over clear so an edge coinciding with a clear is never lost.
        pend_d = ((pend_q & ~clr) | edge_det) & SRC_MASK;

        mask_d = mask_q;
        if (wr_mask) mask_d = bus.OUT_PORT & SRC_MASK;

        iflag_d = iflag_q;
        if (bus.I_CLR)      iflag_d = 1'b0;
        else if (bus.I_SET) iflag_d = 1'b1;

        irq_id_d = irq_id_q;
        if (ack_fire) irq_id_d = ack_idx;
    end

    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            s1_q     <= '0;
            s2_q     <= '0;
            s3_q     <= '0;
            pend_q   <= '0;
            mask_q   <= '0;
            iflag_q  <= 1'b0;
            irq_id_q <= '0;
        end else begin
            s1_q     <= s1_d;
            s2_q     <= s2_d;
            s3_q     <= s3_d;
            pend_q   <= pend_d;
            mask_q   <= mask_d;
            iflag_q  <= iflag_d;
            irq_id_q <= irq_id_d;
        end
    end

    assign bus.INTERUPT = iflag_q & (|active);
    assign bus.I_FLAG   = iflag_q;
    assign bus.IRQ_ID   = irq_id_q;

    always_comb begin
        bus.IN_HIT  = 1'b0;
        bus.IN_DATA = '0;
        if (bus.PORT_ID == MASK_ID) begin
            bus.IN_HIT  = 1'b1;
            bus.IN_DATA = mask_q;
        end else if (bus.PORT_ID == PEND_ID) begin
            bus.IN_HIT  = 1'b1;
            bus.IN_DATA = pend_q;
        end else if (bus.PORT_ID == ID_ID) begin
            bus.IN_HIT  = 1'b1;
            bus.IN_DATA = {5'b0, irq_id_q};
        end
    end
endmodule

// File: tb/tb_interrupt_controller.sv
// Directed testbench for interrupt_controller with hand-computed expectations.
module tb_interrupt_controller;
    localparam logic [7:0] MASK_ID = 8'h20;
    localparam logic [7:0] PEND_ID = 8'h21;
    localparam logic [7:0] ID_ID   = 8'h22;

    logic CLK = 1'b0;
    logic RESET_N;
    int   errors = 0;
    int   checks = 0;
    logic [7:0] rdata;

    interrupt_controller_if #(.NUM_SRC(8)) ifc ();

    interrupt_controller #(
        .NUM_SRC (8),
        .MASK_ID (MASK_ID),
        .PEND_ID (PEND_ID),
        .ID_ID   (ID_ID)
    ) dut (
        .CLK     (CLK),
        .RESET_N (RESET_N),
        .bus     (ifc.slave)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic rd(input logic [7:0] id, output logic [7:0] d);
        ifc.PORT_ID = id;
        #1;
        d = ifc.IN_DATA;
    endtask

    task automatic out_wr(input logic [7:0] id, input logic [7:0] d);
        ifc.IO_STRB  = 1'b1;
        ifc.PORT_ID  = id;
        ifc.OUT_PORT = d;
        tick();
        ifc.IO_STRB  = 1'b0;
        ifc.OUT_PORT = '0;
    endtask

    task automatic ack();
        ifc.INT_ACK = 1'b1;
        tick();
        ifc.INT_ACK = 1'b0;
    endtask

    task automatic set_i();
        ifc.I_SET = 1'b1;
        tick();
        ifc.I_SET = 1'b0;
    endtask

    task automatic test_reset();
        RESET_N = 1'b0;
        ifc.IRQ = 8'hFF;
        tick();
        tick();
        checks++;
        if (ifc.INTERUPT !== 1'b0) begin
            errors++; $display("FAIL reset_interupt got=%b exp=0", ifc.INTERUPT);
        end
        checks++;
        if (ifc.I_FLAG !== 1'b0) begin
            errors++; $display("FAIL reset_iflag got=%b exp=0", ifc.I_FLAG);
        end
        checks++;
        if (ifc.IRQ_ID !== 3'd0) begin
            errors++; $display("FAIL reset_irq_id got=%0d exp=0", ifc.IRQ_ID);
        end
        for (int i = 0; i < 3; i++) begin
            rd(MASK_ID + 8'(i), rdata);
            checks++;
            if (rdata !== 8'h00 || ifc.IN_HIT !== 1'b1) begin
                errors++;
                $display("FAIL reset_read port=%h got=%h hit=%b exp=00 hit=1",
                         MASK_ID + 8'(i), rdata, ifc.IN_HIT);
            end
        end
        rd(8'h23, rdata);
        checks++;
        if (rdata !== 8'h00 || ifc.IN_HIT !== 1'b0) begin
            errors++; $display("FAIL miss_read got=%h hit=%b exp=00 hit=0", rdata, ifc.IN_HIT);
        end
        RESET_N = 1'b1;
        tick();
        tick();
        rd(PEND_ID, rdata);
        checks++;
        if (rdata !== 8'h00) begin
            errors++; $display("FAIL release_pend_early got=%h exp=00", rdata);
        end
        tick();
        rd(PEND_ID, rdata);
        checks++;
        if (rdata !== 8'hFF) begin
            errors++; $display("FAIL release_pend got=%h exp=ff", rdata);
        end
        ifc.IRQ = 8'h00;
        out_wr(PEND_ID, 8'hFF);
        tick();
        tick();
        rd(PEND_ID, rdata);
        checks++;
        if (rdata !== 8'h00) begin
            errors++; $display("FAIL w1c_all got=%h exp=00", rdata);
        end
    endtask

    task automatic test_basic();
        out_wr(MASK_ID, 8'h04);
        set_i();
        checks++;
        if (ifc.I_FLAG !== 1'b1) begin
            errors++; $display("FAIL basic_iflag got=%b exp=1", ifc.I_FLAG);
        end
        ifc.IRQ = 8'h04;
        tick();
        tick();
        checks++;
        if (ifc.INTERUPT !== 1'b0) begin
            errors++; $display("FAIL basic_latency got=%b exp=0 after k+1", ifc.INTERUPT);
        end
        tick();
        checks++;
        if (ifc.INTERUPT !== 1'b1) begin
            errors++; $display("FAIL basic_interupt got=%b exp=1 after k+2", ifc.INTERUPT);
        end
        ifc.I_CLR = 1'b1;
        ack();
        ifc.I_CLR = 1'b0;
        checks++;
        if (ifc.IRQ_ID !== 3'd2) begin
            errors++; $display("FAIL basic_irq_id got=%0d exp=2", ifc.IRQ_ID);
        end
        rd(PEND_ID, rdata);
        checks++;
        if (rdata !== 8'h00) begin
            errors++; $display("FAIL basic_pend got=%h exp=00", rdata);
        end
        checks++;
        if (ifc.INTERUPT !== 1'b0 || ifc.I_FLAG !== 1'b0) begin
            errors++;
            $display("FAIL basic_after_ack int=%b iflag=%b exp=0 0", ifc.INTERUPT, ifc.I_FLAG);
        end
        tick();
        tick();
        rd(PEND_ID, rdata);
        checks++;
        if (rdata !== 8'h00) begin
            errors++; $display("FAIL held_level_no_edge got=%h exp=00", rdata);
        end
        ifc.IRQ = 8'h00;
        tick();
        tick();
        tick();
    endtask

    task automatic test_priority();
        out_wr(MASK_ID, 8'hFF);
        set_i();
        ifc.IRQ = 8'h22;
        tick();
        tick();
        tick();
        ifc.IRQ = 8'h00;
        checks++;
        if (ifc.INTERUPT !== 1'b1) begin
            errors++; $display("FAIL prio_interupt got=%b exp=1", ifc.INTERUPT);
        end
        ack();
        rd(PEND_ID, rdata);
        checks++;
        if (ifc.IRQ_ID !== 3'd1 || rdata !== 8'h20) begin
            errors++; $display("FAIL prio_ack1 id=%0d pend=%h exp id=1 pend=20", ifc.IRQ_ID, rdata);
        end
        checks++;
        if (ifc.INTERUPT !== 1'b1) begin
            errors++; $display("FAIL prio_still_req got=%b exp=1", ifc.INTERUPT);
        end
        ack();
        rd(PEND_ID, rdata);
        checks++;
        if (ifc.IRQ_ID !== 3'd5 || rdata !== 8'h00) begin
            errors++; $display("FAIL prio_ack2 id=%0d pend=%h exp id=5 pend=00", ifc.IRQ_ID, rdata);
        end
        checks++;
        if (ifc.INTERUPT !== 1'b0) begin
            errors++; $display("FAIL prio_done got=%b exp=0", ifc.INTERUPT);
        end
    endtask

    task automatic test_mask_w1c();
        out_wr(MASK_ID, 8'h00);
        ifc.IRQ = 8'h08;
        tick();
        ifc.IRQ = 8'h00;
        tick();
        tick();
        tick();
        rd(PEND_ID, rdata);
        checks++;
        if (rdata !== 8'h08 || ifc.INTERUPT !== 1'b0) begin
            errors++; $display("FAIL masked_pend pend=%h int=%b exp 08 0", rdata, ifc.INTERUPT);
        end
        out_wr(MASK_ID, 8'h08);
        rd(MASK_ID, rdata);
        checks++;
        if (rdata !== 8'h08 || ifc.INTERUPT !== 1'b1) begin
            errors++; $display("FAIL unmask mask=%h int=%b exp 08 1", rdata, ifc.INTERUPT);
        end
        out_wr(ID_ID, 8'h07);
        checks++;
        if (ifc.IRQ_ID !== 3'd5) begin
            errors++; $display("FAIL id_readonly got=%0d exp=5", ifc.IRQ_ID);
        end
        out_wr(PEND_ID, 8'h08);
        rd(PEND_ID, rdata);
        checks++;
        if (rdata !== 8'h00 || ifc.INTERUPT !== 1'b0) begin
            errors++; $display("FAIL w1c pend=%h int=%b exp 00 0", rdata, ifc.INTERUPT);
        end
    endtask

    task automatic test_simultaneous();
        ifc.IRQ = 8'h01;
        tick();
        tick();
        out_wr(PEND_ID, 8'h01);
        rd(PEND_ID, rdata);
        checks++;
        if (rdata !== 8'h01) begin
            errors++; $display("FAIL edge_vs_w1c got=%h exp=01", rdata);
        end
        ifc.IRQ = 8'h00;
        out_wr(PEND_ID, 8'h01);
        rd(PEND_ID, rdata);
        checks++;
        if (rdata !== 8'h00) begin
            errors++; $display("FAIL w1c_bit0 got=%h exp=00", rdata);
        end
        checks++;
        if (ifc.I_FLAG !== 1'b1) begin
            errors++; $display("FAIL iflag_pre got=%b exp=1", ifc.I_FLAG);
        end
        ifc.I_SET = 1'b1;
        ifc.I_CLR = 1'b1;
        tick();
        ifc.I_SET = 1'b0;
        ifc.I_CLR = 1'b0;
        checks++;
        if (ifc.I_FLAG !== 1'b0) begin
            errors++; $display("FAIL set_clr_both got=%b exp=0", ifc.I_FLAG);
        end
        ack();
        checks++;
        if (ifc.IRQ_ID !== 3'd5) begin
            errors++; $display("FAIL spurious_ack got=%0d exp=5", ifc.IRQ_ID);
        end
    endtask

    task automatic test_reset_mid();
        out_wr(MASK_ID, 8'hFF);
        set_i();
        ifc.IRQ = 8'h1A;
        tick();
        tick();
        tick();
        ifc.IRQ = 8'h00;
        rd(PEND_ID, rdata);
        checks++;
        if (rdata !== 8'h1A || ifc.INTERUPT !== 1'b1) begin
            errors++; $display("FAIL mid_pre pend=%h int=%b exp 1a 1", rdata, ifc.INTERUPT);
        end
        RESET_N = 1'b0;
        tick();
        RESET_N = 1'b1;
        rd(PEND_ID, rdata);
        checks++;
        if (rdata !== 8'h00) begin
            errors++; $display("FAIL mid_pend got=%h exp=00", rdata);
        end
        rd(MASK_ID, rdata);
        checks++;
        if (rdata !== 8'h00) begin
            errors++; $display("FAIL mid_mask got=%h exp=00", rdata);
        end
        checks++;
        if (ifc.IRQ_ID !== 3'd0 || ifc.INTERUPT !== 1'b0 || ifc.I_FLAG !== 1'b0) begin
            errors++;
            $display("FAIL mid_outputs id=%0d int=%b iflag=%b exp 0 0 0",
                     ifc.IRQ_ID, ifc.INTERUPT, ifc.I_FLAG);
        end
        tick();
        tick();
        tick();
        rd(PEND_ID, rdata);
        checks++;
        if (rdata !== 8'h00) begin
            errors++; $display("FAIL mid_no_ghost got=%h exp=00", rdata);
        end
    endtask

    initial begin
        RESET_N      = 1'b0;
        ifc.IRQ      = '0;
        ifc.I_SET    = 1'b0;
        ifc.I_CLR    = 1'b0;
        ifc.INT_ACK  = 1'b0;
        ifc.IO_STRB  = 1'b0;
        ifc.PORT_ID  = '0;
        ifc.OUT_PORT = '0;
        test_reset();
        test_basic();
        test_priority();
        test_mask_w1c();
        test_simultaneous();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
